// File: rtl/sysid_check_master.sv
// Avalon-MM read master that checks the system-ID slave: reads ID and build timestamp, reports pass/fail.
// Optional SYSID_CHECK_RETRY_EN: up to two further attempts before a failure becomes final.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476686285,
    parameter int          START_DELAY        = 16,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    typedef enum logic [2:0] {
        S_WAIT, S_RD_ID, S_RD_TS, S_CHECK, S_DONE, S_RETRY
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] delay_cnt_q, delay_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] timestamp_value_q, timestamp_value_d;

    logic        rd_active;
    logic        accept;
    logic        stall_expired;
    logic        give_up;
    logic [1:0]  check_code;

    assign rd_active     = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign accept        = rd_active && !avm_waitrequest;
    assign stall_expired = rd_active && avm_waitrequest && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    // ID mismatch takes priority over timestamp mismatch
    assign check_code    = (id_value_q != EXPECTED_ID)               ? 2'd1 :
                           (timestamp_value_q != EXPECTED_TIMESTAMP) ? 2'd2 : 2'd0;

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] attempt_q, attempt_d;
    assign give_up = (attempt_q == 2'd2);
`else
    assign give_up = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_WAIT;
            delay_cnt_q       <= '0;
            to_cnt_q          <= '0;
            avm_read_q        <= 1'b0;
            avm_address_q     <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fail_code_q       <= 2'd0;
            id_value_q        <= '0;
            timestamp_value_q <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            attempt_q         <= 2'd0;
`endif
        end else begin
            state_q           <= state_d;
            delay_cnt_q       <= delay_cnt_d;
            to_cnt_q          <= to_cnt_d;
            avm_read_q        <= avm_read_d;
            avm_address_q     <= avm_address_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            fail_code_q       <= fail_code_d;
            id_value_q        <= id_value_d;
            timestamp_value_q <= timestamp_value_d;
`ifdef SYSID_CHECK_RETRY_EN
            attempt_q         <= attempt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        to_cnt_d    = to_cnt_q;
`ifdef SYSID_CHECK_RETRY_EN
        attempt_d   = attempt_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (delay_cnt_q == 16'(START_DELAY - 1)) state_d = S_RD_ID;
                else                                     delay_cnt_d = delay_cnt_q + 16'd1;
            end
            S_RD_ID, S_RD_TS: begin
                if (accept) begin
                    to_cnt_d = '0;
                    state_d  = (state_q == S_RD_ID) ? S_RD_TS : S_CHECK;
                end else if (stall_expired) begin
                    to_cnt_d = '0;
                    state_d  = give_up ? S_DONE : S_RETRY;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_CHECK: state_d = ((check_code == 2'd0) || give_up) ? S_DONE : S_RETRY;
            S_RETRY: state_d = S_RD_ID;
            S_DONE:  if (start) state_d = S_RD_ID;
            default: state_d = S_WAIT;
        endcase
`ifdef SYSID_CHECK_RETRY_EN
        if (state_d == S_RETRY)                attempt_d = attempt_q + 2'd1;
        else if (state_q == S_DONE && start)   attempt_d = 2'd0;
`endif
    end

    // Outputs are registered from the next state so the bus sees clean, glitch-free strobes
    always_comb begin
        avm_read_d        = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        avm_address_d     = (state_d == S_RD_TS);
        busy_d            = (state_d == S_RD_ID) || (state_d == S_RD_TS) ||
                            (state_d == S_CHECK) || (state_d == S_RETRY);
        done_d            = (state_d == S_DONE);
        pass_d            = pass_q;
        fail_code_d       = fail_code_q;
        id_value_d        = id_value_q;
        timestamp_value_d = timestamp_value_q;
        if (state_q == S_RD_ID && accept) id_value_d        = avm_readdata;
        if (state_q == S_RD_TS && accept) timestamp_value_d = avm_readdata;
        if (state_q == S_DONE && start) begin
            pass_d      = 1'b0;
            fail_code_d = 2'd0;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            if (state_q == S_CHECK) begin
                pass_d      = (check_code == 2'd0);
                fail_code_d = check_code;
            end else begin
                pass_d      = 1'b0;
                fail_code_d = 2'd3;
            end
        end
    end

    assign avm_read        = avm_read_q;
    assign avm_address     = avm_address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail_code       = fail_code_q;
    assign id_value        = id_value_q;
    assign timestamp_value = timestamp_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master: a stalling slave model plus an outcome/latency predictor.
`timescale 1ns/1ps
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1476686285;
    localparam int DELAY = 16;
    localparam int TMO   = 255;
    localparam int PERM  = 100000;
`ifdef SYSID_CHECK_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_address, avm_read, busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] id_value, timestamp_value;

    sysid_check_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
        .START_DELAY(DELAY), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .id_value(id_value), .timestamp_value(timestamp_value)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Slave configuration (written by the main sequence only while the DUT is idle)
    logic [31:0] id_words[3];
    logic [31:0] ts_words[3];
    int stall_id = 0, stall_ts = 0;
    int id_base = 0, ts_base = 0;

    // Slave bookkeeping (written by the slave process only)
    int edge_cnt = 0;
    int id_acc = 0, ts_acc = 0;
    int last_id_edge = 0, last_ts_edge = 0;
    int proto_viol = 0;

    // Model of what the DUT should have captured
    logic [31:0] m_id = 32'd0, m_ts = 32'd0;

    initial forever begin
        @(posedge clock);
        edge_cnt++;
    end

    // Slave: decides waitrequest/readdata at each falling edge for the following rising edge
    initial begin : slave
        bit in_read;
        bit prev_stall;
        logic prev_addr;
        int remain;
        int k;
        in_read = 0; prev_stall = 0; prev_addr = 0; remain = 0;
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1 || avm_read !== 1'b1) begin
                in_read = 0;
                prev_stall = 0;
                avm_waitrequest = 1'b0;
            end else begin
                if (prev_stall && avm_address !== prev_addr) proto_viol++;
                if (!in_read) begin
                    in_read = 1;
                    remain = avm_address ? stall_ts : stall_id;
                end
                prev_addr = avm_address;
                if (remain > 0) begin
                    remain--;
                    avm_waitrequest = 1'b1;
                    avm_readdata = $urandom;
                    prev_stall = 1;
                end else begin
                    avm_waitrequest = 1'b0;
                    prev_stall = 0;
                    in_read = 0;
                    if (avm_address == 1'b0) begin
                        k = id_acc - id_base; if (k > 2) k = 2;
                        avm_readdata = id_words[k];
                        id_acc++;
                        last_id_edge = edge_cnt + 1;
                    end else begin
                        k = ts_acc - ts_base; if (k > 2) k = 2;
                        avm_readdata = ts_words[k];
                        ts_acc++;
                        last_ts_edge = edge_cnt + 1;
                    end
                end
            end
            if (done === 1'b1 && avm_read !== 1'b0) proto_viol++;
        end
    end

    // Outcome predictor: attempt-by-attempt, from stall lengths and returned words
    task automatic predict(output int lat, output logic [1:0] fc, output int reads);
        lat = 0; reads = 0; fc = 2'd0;
        for (int a = 0; a < TRIES; a++) begin
            if (a > 0) lat++;
            if (stall_id >= TMO) begin
                lat += TMO; fc = 2'd3;
            end else begin
                lat += stall_id + 1;
                m_id = id_words[a];
                reads++;
                if (stall_ts >= TMO) begin
                    lat += TMO; fc = 2'd3;
                end else begin
                    lat += stall_ts + 2;
                    m_ts = ts_words[a];
                    if (m_id != EXP_ID)      fc = 2'd1;
                    else if (m_ts != EXP_TS) fc = 2'd2;
                    else                     fc = 2'd0;
                end
            end
            if (fc == 2'd0) break;
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [1:0] exp_fc, input int exp_reads, input int pv0);
        check_eq({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check_eq({tag, ".done"},  32'(done), 32'd1);
        check_eq({tag, ".busy"},  32'(busy), 32'd0);
        check_eq({tag, ".pass"},  32'(pass), 32'(exp_fc == 2'd0));
        check_eq({tag, ".fc"},    32'(fail_code), 32'(exp_fc));
        check_eq({tag, ".id"},    id_value, m_id);
        check_eq({tag, ".ts"},    timestamp_value, m_ts);
        check_eq({tag, ".reads"}, 32'(id_acc - id_base), 32'(exp_reads));
        repeat (2) @(negedge clock);
        check_eq({tag, ".hold"},  {29'd0, done, fail_code}, {29'd1, exp_fc});
        check_eq({tag, ".rdlow"}, 32'(avm_read), 32'd0);
        check_eq({tag, ".proto"}, 32'(proto_viol - pv0), 32'd0);
        $display("run %s: lat=%0d pass=%0d fail_code=%0d id=0x%h ts=0x%h",
                 tag, lat, pass, fail_code, id_value, timestamp_value);
    endtask

    // One start-triggered check; optionally holds start into the busy phase
    task automatic do_run(input string tag, input bit pulse_busy);
        int n0, lat, exp_lat, exp_reads, k, pv0;
        logic [1:0] exp_fc;
        id_base = id_acc; ts_base = ts_acc; pv0 = proto_viol;
        predict(exp_lat, exp_fc, exp_reads);
        start = 1'b1;
        @(negedge clock);
        n0 = edge_cnt;
        check_eq({tag, ".clr"}, {28'd0, done, pass, fail_code}, 32'd0);
        check_eq({tag, ".rd0"}, {30'd0, busy, avm_read}, 32'd3);
        check_eq({tag, ".a0"},  32'(avm_address), 32'd0);
        start = pulse_busy;
        @(negedge clock);
        start = 1'b0;
        wait_done(k);
        lat = edge_cnt - n0;
        check_result(tag, lat, exp_lat, exp_fc, exp_reads, pv0);
    endtask

    // Automatic check after reset release
    task automatic auto_run(input string tag);
        int n0, lat, exp_lat, exp_reads, k, pv0;
        logic [1:0] exp_fc;
        id_base = id_acc; ts_base = ts_acc; pv0 = proto_viol;
        predict(exp_lat, exp_fc, exp_reads);
        reset_n = 1'b1;
        n0 = edge_cnt;
        @(negedge clock);
        check_eq({tag, ".wait"}, {30'd0, busy, avm_read}, 32'd0);
        wait_done(k);
        lat = edge_cnt - n0;
        check_eq({tag, ".id_edge"}, 32'(last_id_edge - n0), 32'(DELAY + 1));
        check_eq({tag, ".ts_edge"}, 32'(last_ts_edge - n0), 32'(DELAY + 2));
        check_result(tag, lat, exp_lat + DELAY, exp_fc, exp_reads, pv0);
    endtask

    task automatic set_words(input logic [31:0] idw, input logic [31:0] tsw);
        for (int a = 0; a < 3; a++) begin
            id_words[a] = idw;
            ts_words[a] = tsw;
        end
    endtask

    initial begin : main
        int k;
        set_words(EXP_ID, EXP_TS);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst.outs", {27'd0, avm_read, avm_address, busy, done, pass},   32'd0);
        check_eq("rst.vals", {30'd0, fail_code} | id_value | timestamp_value,     32'd0);

        auto_run("boot");

        set_words(32'h5, EXP_TS);
        do_run("id_bad", 1'b1);

        set_words(32'd7, 32'd9);
        do_run("both_bad", 1'b0);

        set_words(EXP_ID, 32'h1234);
        do_run("ts_bad", 1'b0);

        set_words(EXP_ID, EXP_TS);
        stall_ts = 3;
        do_run("ts_stall3", 1'b0);

        stall_ts = PERM;
        do_run("ts_timeout", 1'b0);

        stall_ts = 0; stall_id = PERM;
        do_run("id_timeout", 1'b0);
        stall_id = 0;

        id_words[0] = 32'h5; id_words[1] = 32'h6; id_words[2] = EXP_ID;
        do_run("bad_bad_good", 1'b0);

        // Reset asserted while the timestamp read is stalled
        set_words(EXP_ID, EXP_TS);
        stall_ts = 6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(avm_read === 1'b1 && avm_address === 1'b1) && k < 50) begin
            @(negedge clock);
            k++;
        end
        check_eq("mid.reach_ts", 32'(k < 50), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid.outs", {27'd0, avm_read, avm_address, busy, done, pass}, 32'd0);
        check_eq("mid.vals", {30'd0, fail_code} | id_value | timestamp_value,  32'd0);
        repeat (2) @(negedge clock);
        m_id = 32'd0; m_ts = 32'd0;
        stall_ts = 0;
        set_words(EXP_ID, 32'hDEAD_BEEF);
        auto_run("reboot");

        for (int i = 0; i < 20; i++) begin
            for (int a = 0; a < 3; a++) begin
                id_words[a] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
                ts_words[a] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            end
            stall_id = ($urandom_range(0, 11) == 0) ? PERM : int'($urandom_range(0, 3));
            stall_ts = ($urandom_range(0, 11) == 0) ? PERM : int'($urandom_range(0, 3));
            do_run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its readdata.
- After reset, and on each start request, it reads address 0 (system ID) and address 1 (build timestamp).
- It compares both words against expected parameter values and presents registered done/pass/fail status plus the captured words.
- Software and the LED/debug logic use the result to detect a stale or mismatched FPGA image before the game logic runs.

Parameters:
EXPECTED_ID, 32'd0, value that must be read at sysid address 0
EXPECTED_TIMESTAMP, 32'd1476686285, value that must be read at sysid address 1
START_DELAY, 16, cycles to wait after reset deassertion before the first automatic check (1..65535)
TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles per read before abort (1..65535)

Ports:
clock  in  1  system clock; all state is updated on its rising edge
reset_n  in  1  reset; asynchronous assertion, active-low
start  in  1  single-cycle request to re-run the check; honoured only in state DONE
avm_address  out  1  read address to the sysid slave (0 = ID, 1 = timestamp)
avm_read  out  1  read strobe
avm_waitrequest  in  1  slave stall; tie low when the slave has none
avm_readdata  in  32  slave read data, valid in the accept cycle (read latency 0)
busy  out  1  high from the end of the start delay until done rises
done  out  1  check complete; held until the next start is accepted
pass  out  1  valid while done=1; 1 = both words matched
fail_code  out  2  valid while done=1; 0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
id_value  out  32  last captured ID word
timestamp_value  out  32  last captured timestamp word

Behaviour:
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, fail_code=0, id_value=0, timestamp_value=0. State goes to WAIT; delay and timeout counters clear.
- Reset asserted mid-operation aborts immediately to these values; the slave tolerates a dropped read.
- Read acceptance: a read is accepted in a cycle where avm_read=1 and avm_waitrequest=0. avm_readdata is captured in that same cycle.
- While waitrequest=1: avm_read and avm_address hold stable.
- avm_read is never high outside RD_ID/RD_TS.
- WAIT: counts START_DELAY cycles, then goes to RD_ID.
- RD_ID: avm_address=0, avm_read=1, busy=1. On accept, capture id_value and go to RD_TS.
- RD_TS: avm_address=1, avm_read=1. On accept, capture timestamp_value and go to CHECK.
- CHECK (1 cycle): compute result, then go to DONE.
  - fail_code=1 if id_value != EXPECTED_ID.
  - Else fail_code=2 if timestamp_value != EXPECTED_TIMESTAMP.
  - Else pass=1, fail_code=0.
  - If both words mismatch, ID has priority: fail_code=1.
- DONE: done=1, busy=0, status held. start=1 clears done, pass and fail_code on the next edge and goes to RD_ID (no start delay).
- start in any other state is ignored and not queued.
- Timeout: the per-read counter increments each cycle avm_read=1 and waitrequest=1, and clears on accept.
  - When it reaches TIMEOUT_CYCLES, drop avm_read and go to DONE with pass=0, fail_code=3.
  - The captured word for the aborted read keeps its prior value.
- Latency with waitrequest tied low, counting the first edge after reset_n rises as edge 1:
  - RD_ID occupies edge START_DELAY+1, RD_TS edge START_DELAY+2, CHECK edge START_DELAY+3.
  - done is high from edge START_DELAY+3.
  - A start accepted at edge N gives done high from edge N+3.
- Outputs are registered; no combinational path from inputs to outputs except nothing (avm_* driven from state).

Optional Feature:
- Macro: SYSID_CHECK_RETRY_EN.
- Defined: a mismatch or timeout detected in CHECK or RD_*:
  - Returns to RD_ID after one idle cycle, up to 2 further attempts.
  - Only the third consecutive failure reaches DONE with its fail_code.
  - Any passing attempt reaches DONE with pass=1.
  - The attempt counter clears on reset and on each accepted start.
- Undefined: the first failure is final, with no retry logic synthesized.

Test Plan:
- Reset release, waitrequest=0, slave returns 0 then 1476686285, START_DELAY=16 -> avm_read high at edges 17-18 with address 0 then 1; done=1, pass=1, fail_code=0 at edge 19.
- Slave returns 0x00000005 at address 0 -> done=1, pass=0, fail_code=1, id_value=5.
- Both words wrong (7, 9) -> fail_code=1 (priority), timestamp_value=9.
- waitrequest held high 3 cycles on the timestamp read -> avm_address=1 stable 4 cycles, data captured on the 4th, pass=1. Then waitrequest held high permanently, TIMEOUT_CYCLES=255 -> fail_code=3 after 255 stall cycles, avm_read low afterwards.
- start pulsed while busy -> ignored. start pulsed in DONE at edge N -> done low at N, high again at N+3. reset_n low during RD_TS -> all outputs 0 immediately.
- With SYSID_CHECK_RETRY_EN and a wrong ID twice then correct -> three address-0 reads seen, final pass=1. Always wrong -> fail_code=1 only after the third attempt.
